trng_sampler: RTL and testbench
===============================

TRNG_SAMPLER -- requirements
Module: trng_sampler

Interface
REQ-001 Parameter: DECIM, default 4, clk cycles per raw sample tick (range 1..255).
REQ-002 Parameter: RCT_LIMIT, default 32, consecutive identical raw samples that declare a health failure (range 2..255).
REQ-003 Port: clk  in  1  single system clock; all logic on posedge clk.
REQ-004 Port: rst  in  1  synchronous, active-high reset.
REQ-005 Port: ring_in  in  1  ring-oscillator output, asynchronous to clk.
REQ-006 Port: en  in  1  sampling enable.
REQ-007 Port: data_out  out  8  entropy byte.
REQ-008 Port: data_valid  out  1  data_out holds an unconsumed byte.
REQ-009 Port: data_ready  in  1  consumer accepts the byte.
REQ-010 Port: health_fail  out  1  sticky health-test failure flag.

Function
REQ-011 ring_in SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 While en=1 and the block is not in FAIL, a decimation counter SHALL raise a one-cycle tick every DECIM clk cycles; the raw bit is the synchronizer output on the tick cycle.
REQ-013 FSM states: IDLE (en=0), FILL (collecting bits), HOLD (byte pending), FAIL; IDLE->FILL when en=1; FILL->HOLD when 8 bits have been accepted; HOLD->FILL on valid&&ready; any state->FAIL on a health failure; FAIL exits only on rst.
REQ-014 Accepted bits SHALL be packed LSB-first: the first accepted bit lands in data_out[0].
REQ-015 The 8th accepted bit SHALL load data_out, and data_valid SHALL be 1 on the following cycle.
REQ-016 data_out SHALL be stable while data_valid=1; the transfer occurs on the cycle with data_valid&&data_ready, and data_valid SHALL be 0 the next cycle unless a new byte completes on that same cycle.
REQ-017 Ticks SHALL continue in HOLD and fill a second, internal shift register; if it completes while a byte is still pending, that byte is discarded and the shift register restarts from zero bits.
REQ-018 If en falls, the decimation counter, partial byte and debias pair state SHALL clear; a pending data_out/data_valid SHALL persist until transferred.
REQ-019 Health test: a run counter SHALL count consecutive identical raw bits (it restarts at 1 on a change); when it reaches RCT_LIMIT, the block enters FAIL.
REQ-020 In FAIL: health_fail=1, data_valid=0, no further ticks.
REQ-021 Counters SHALL saturate and never wrap.

Reset
REQ-022 On rst=1 at a clk edge:
- data_out=0, data_valid=0, health_fail=0
- FSM=IDLE
- all counters, shift registers, synchronizer and pair state cleared
REQ-023 rst mid-byte or mid-HOLD SHALL discard all data; rst overrides en and data_ready on the same cycle.

Configuration
REQ-024 Macro TRNG_VN_DEBIAS_EN, when defined, SHALL apply von Neumann debiasing:
- raw bits are paired in tick order
- pair 01 accepts bit 0, pair 10 accepts bit 1
- pairs 00 and 11 are dropped
REQ-025 When TRNG_VN_DEBIAS_EN is undefined, every raw bit SHALL be accepted directly; the health test SHALL operate on raw bits in both builds.

Structure
REQ-026 The shared package trng_pkg SHALL hold the FSM state typedef, the byte width constant (8) and the default DECIM/RCT_LIMIT values.
REQ-027 The synchronizer SHALL be a sub-module named sync_2ff; all other logic stays in trng_sampler.

Verification
REQ-028 Bench conditions: DECIM=4, RCT_LIMIT=32; ring_in is driven synchronously so that each tick samples a chosen value.
REQ-029 Debias build, raw sequence 0,1 repeated 8 times -> data_out=0x00, data_valid=1 one cycle after the 16th tick.
REQ-030 Debias build, raw sequence 1,0 x8 -> data_out=0xFF; a raw sequence 0,0,1,1 x8 produces no byte.
REQ-031 No-debias build, raw 1,0,1,0,1,0,1,0 -> data_out=0x55; holding data_ready=0 for 40 further ticks keeps data_out=0x55 stable.
REQ-032 ring_in held at 1 with en=1 -> health_fail=1 after exactly 32 ticks, data_valid=0 thereafter; rst clears health_fail.
REQ-033 en dropped after 5 accepted bits, then raised again -> the next byte contains only bits accepted after re-enable.
REQ-034 rst asserted while data_valid=1 -> data_valid=0 and data_out=0 on the next cycle.

Source files
------------

// File: rtl/trng_pkg.sv
// Shared types and defaults for the TRNG sampler.
package trng_pkg;

  localparam int BYTE_W        = 8;
  localparam int DECIM_DEF     = 4;
  localparam int RCT_LIMIT_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the asynchronous ring-oscillator input.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  // Metastability filter chain
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/trng_sampler.sv
// Decimating ring-oscillator sampler with repetition-count health test.
// Optional von Neumann debiasing is enabled by defining TRNG_VN_DEBIAS_EN.
module trng_sampler
  import trng_pkg::*;
#(
  parameter int DECIM     = DECIM_DEF,
  parameter int RCT_LIMIT = RCT_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ring_in,
  input  logic              en,
  output logic [BYTE_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              health_fail
);

  localparam logic [7:0] DEC_MAX = 8'(DECIM - 1);
  localparam logic [7:0] RCT_MAX = 8'(RCT_LIMIT);

  logic              w_ring_s;
  state_t            r_state, w_state_nxt;
  logic [7:0]        r_dcnt;
  logic [7:0]        r_run;
  logic              r_last;
  logic [6:0]        r_shift;
  logic [2:0]        r_cnt;
  logic [BYTE_W-1:0] r_data;
  logic              r_valid;
  logic              r_hfail;

  logic              w_active, w_tick, w_trip, w_acc, w_acc_bit;
  logic              w_complete, w_load, w_xfer, w_valid_nxt;
  logic [7:0]        w_run_nxt;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (ring_in),
    .q   (w_ring_s)
  );

  assign w_active  = en && (r_state != ST_FAIL);
  assign w_tick    = w_active && (r_dcnt == DEC_MAX);
  assign w_run_nxt = ((r_run == 8'd0) || (w_ring_s != r_last)) ? 8'd1 : sat_inc8(r_run);
  assign w_trip    = w_tick && (w_run_nxt == RCT_MAX);

`ifdef TRNG_VN_DEBIAS_EN
  logic r_pair_have;
  logic r_pair_bit;

  // Only the second raw bit of an unequal pair yields an output bit
  assign w_acc     = w_tick && !w_trip && r_pair_have && (r_pair_bit != w_ring_s);
  assign w_acc_bit = r_pair_bit;

  // Raw-bit pairing in tick order
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      r_pair_have <= 1'b0;
      r_pair_bit  <= 1'b0;
    end else if (w_tick && !w_trip) begin
      r_pair_have <= !r_pair_have;
      r_pair_bit  <= w_ring_s;
    end else begin
      r_pair_have <= r_pair_have;
      r_pair_bit  <= r_pair_bit;
    end
  end
`else
  assign w_acc     = w_tick && !w_trip;
  assign w_acc_bit = w_ring_s;
`endif

  assign w_complete = w_acc && (r_cnt == 3'd7);
  assign w_xfer     = r_valid && data_ready;
  // A byte completing while the previous one stays pending is dropped
  assign w_load     = w_complete && (!r_valid || data_ready);

  always_comb begin
    w_valid_nxt = r_valid;
    if (w_trip) begin
      w_valid_nxt = 1'b0;
    end else if (w_load) begin
      w_valid_nxt = 1'b1;
    end else if (w_xfer) begin
      w_valid_nxt = 1'b0;
    end else begin
      w_valid_nxt = r_valid;
    end
  end

  // Next-state logic; FAIL is left only through rst
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FAIL: w_state_nxt = ST_FAIL;
      default: begin
        if (w_trip) begin
          w_state_nxt = ST_FAIL;
        end else if (!en) begin
          w_state_nxt = ST_IDLE;
        end else if (w_valid_nxt) begin
          w_state_nxt = ST_HOLD;
        end else begin
          w_state_nxt = ST_FILL;
        end
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Decimation counter
  always_ff @(posedge clk) begin
    if (rst || !w_active || w_tick) begin
      r_dcnt <= 8'd0;
    end else begin
      r_dcnt <= r_dcnt + 8'd1;
    end
  end

  // Repetition-count health test on raw bits; survives en toggles
  always_ff @(posedge clk) begin
    if (rst) begin
      r_run  <= 8'd0;
      r_last <= 1'b0;
    end else if (w_tick) begin
      r_run  <= w_run_nxt;
      r_last <= w_ring_s;
    end else begin
      r_run  <= r_run;
      r_last <= r_last;
    end
  end

  // LSB-first collection of accepted bits
  always_ff @(posedge clk) begin
    if (rst || !en || w_complete) begin
      r_shift <= 7'd0;
      r_cnt   <= 3'd0;
    end else if (w_acc) begin
      r_shift[r_cnt] <= w_acc_bit;
      r_cnt          <= r_cnt + 3'd1;
    end else begin
      r_shift <= r_shift;
      r_cnt   <= r_cnt;
    end
  end

  // Output byte, handshake and sticky health flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_hfail <= 1'b0;
    end else begin
      if (w_load) begin
        r_data <= {w_acc_bit, r_shift};
      end else begin
        r_data <= r_data;
      end
      r_valid <= w_valid_nxt;
      r_hfail <= r_hfail || w_trip;
    end
  end

  assign data_out    = r_data;
  assign data_valid  = r_valid;
  assign health_fail = r_hfail;

endmodule

// File: tb/tb_trng_sampler.sv
// Randomized self-checking bench for trng_sampler against a bit-list reference model.
module tb_trng_sampler;

  localparam int DECIM = 4;
  localparam int RCT   = 32;
`ifdef TRNG_VN_DEBIAS_EN
  localparam bit DEBIAS = 1'b1;
`else
  localparam bit DEBIAS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ring_in = 1'b0;
  logic       en = 1'b0;
  logic       data_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       health_fail;

  int n_vec = 0;
  int n_err = 0;

  trng_sampler #(.DECIM(DECIM), .RCT_LIMIT(RCT)) dut (
    .clk         (clk),
    .rst         (rst),
    .ring_in     (ring_in),
    .en          (en),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .health_fail (health_fail)
  );

  always #5 clk = ~clk;

  // Reference model: raw-bit history, pairing and accepted-bit list
  bit         m_fail, m_valid, m_last, m_pair_have, m_pair_first;
  logic [7:0] m_out;
  int         m_run;
  bit         m_bits[$];

  function automatic void m_reset();
    m_fail = 0; m_valid = 0; m_last = 0; m_pair_have = 0; m_pair_first = 0;
    m_out = 8'h00; m_run = 0; m_bits.delete();
  endfunction

  function automatic void m_disable();
    m_bits.delete();
    m_pair_have = 0;
  endfunction

  function automatic void m_tick(bit b, bit rdy);
    bit pending, acc, acc_bit;
    logic [7:0] byt;
    if (m_fail) return;
    pending = m_valid && !rdy;
    if (m_run == 0 || b != m_last) m_run = 1;
    else if (m_run < 255) m_run++;
    m_last = b;
    if (m_run == RCT) begin
      m_fail = 1; m_valid = 0;
      return;
    end
    if (rdy) m_valid = 0;
    acc = 0; acc_bit = b;
    if (!DEBIAS) acc = 1;
    else if (!m_pair_have) begin m_pair_have = 1; m_pair_first = b; end
    else begin
      m_pair_have = 0;
      if (m_pair_first != b) begin acc = 1; acc_bit = m_pair_first; end
    end
    if (acc) begin
      m_bits.push_back(acc_bit);
      if (m_bits.size() == 8) begin
        byt = 8'h00;
        for (int i = 0; i < 8; i++) byt[i] = m_bits[i];
        m_bits.delete();
        if (!pending) begin m_out = byt; m_valid = 1; end
      end
    end
  endfunction

  // One decimation period; rmode 0 = no ready, 1 = ready on first edge, 2 = ready on tick edge
  task automatic do_tick(input bit b, input int rmode);
    ring_in = b;
    for (int e = 1; e <= DECIM; e++) begin
      data_ready = (rmode == 1 && e == 1) || (rmode == 2 && e == DECIM);
      @(posedge clk);
      if (e < DECIM && data_ready && !m_fail) m_valid = 0;
      #1;
    end
    data_ready = 1'b0;
    m_tick(b, rmode == 2);
  endtask

  task automatic feed_acc(input bit b);
    do_tick(b, 0);
    if (DEBIAS) do_tick(!b, 0);
  endtask

  task automatic do_rst();
    rst = 1'b1; en = 1'b0; data_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; data_ready = 1'b1; ring_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; en = 1'b0; data_ready = 1'b0;
    m_reset();
    n_vec++;
    if (data_out !== 8'h00 || data_valid !== 1'b0 || health_fail !== 1'b0) begin
      n_err++;
      $display("FAIL reset: out=%h valid=%b hf=%b required out=00 valid=0 hf=0", data_out, data_valid, health_fail);
    end
  endtask

  task automatic test_patterns();
    do_rst();
    en = 1'b1;
    if (DEBIAS) begin
      for (int i = 0; i < 16; i++) begin
        do_tick(i[0], 0);
        if (i == 14) begin
          n_vec++;
          if (data_valid !== 1'b0) begin n_err++; $display("FAIL vn01_early: valid=%b required 0", data_valid); end
        end
      end
      n_vec++;
      if (data_valid !== 1'b1 || data_out !== 8'h00) begin
        n_err++; $display("FAIL vn01: out=%h valid=%b required 00/1", data_out, data_valid);
      end
      for (int i = 0; i < 16; i++) do_tick(!i[0], (i == 0) ? 1 : 0);
      n_vec++;
      if (data_valid !== 1'b1 || data_out !== 8'hFF) begin
        n_err++; $display("FAIL vn10: out=%h valid=%b required FF/1", data_out, data_valid);
      end
      for (int i = 0; i < 32; i++) do_tick(i[1], (i == 0) ? 1 : 0);
      n_vec++;
      if (data_valid !== 1'b0 || data_out !== 8'hFF) begin
        n_err++; $display("FAIL vn0011: out=%h valid=%b required FF/0", data_out, data_valid);
      end
    end else begin
      for (int i = 0; i < 8; i++) do_tick(!i[0], 0);
      n_vec++;
      if (data_valid !== 1'b1 || data_out !== 8'h55) begin
        n_err++; $display("FAIL raw55: out=%h valid=%b required 55/1", data_out, data_valid);
      end
      for (int i = 0; i < 40; i++) begin
        do_tick(1'($urandom_range(0, 1)), 0);
        n_vec++;
        if (data_valid !== 1'b1 || data_out !== 8'h55) begin
          n_err++; $display("FAIL hold55 tick %0d: out=%h valid=%b required 55/1", i, data_out, data_valid);
        end
      end
      do_tick(1'($urandom_range(0, 1)), 1);
      n_vec++;
      if (data_valid !== m_valid) begin
        n_err++; $display("FAIL consume55: valid=%b required %b", data_valid, m_valid);
      end
    end
  endtask

  task automatic test_random();
    do_rst();
    en = 1'b1;
    for (int i = 0; i < 240; i++) begin
      do_tick(1'($urandom_range(0, 1)), $urandom_range(0, 2));
      n_vec++;
      if (data_valid !== m_valid || data_out !== m_out || health_fail !== m_fail) begin
        n_err++;
        $display("FAIL random tick %0d: out=%h valid=%b hf=%b required %h/%b/%b",
                 i, data_out, data_valid, health_fail, m_out, m_valid, m_fail);
      end
    end
  endtask

  task automatic test_enable_drop();
    logic [7:0] exp;
    bit b;
    do_rst();
    en = 1'b1;
    for (int i = 0; i < 5; i++) feed_acc(1'($urandom_range(0, 1)));
    en = 1'b0;
    m_disable();
    repeat (3) @(posedge clk);
    #1;
    en = 1'b1;
    exp = 8'h00;
    for (int i = 0; i < 8; i++) begin
      b = 1'($urandom_range(0, 1));
      exp[i] = b;
      feed_acc(b);
    end
    n_vec++;
    if (data_valid !== 1'b1 || data_out !== exp || data_out !== m_out) begin
      n_err++; $display("FAIL en_drop: out=%h valid=%b required %h/1", data_out, data_valid, exp);
    end
  endtask

  task automatic test_health();
    do_rst();
    en = 1'b1;
    for (int i = 0; i < RCT - 1; i++) do_tick(1'b1, 0);
    n_vec++;
    if (health_fail !== 1'b0) begin n_err++; $display("FAIL hf_early: hf=%b required 0", health_fail); end
    do_tick(1'b1, 0);
    n_vec++;
    if (health_fail !== 1'b1 || data_valid !== 1'b0 || health_fail !== m_fail) begin
      n_err++; $display("FAIL hf_trip: hf=%b valid=%b required 1/0", health_fail, data_valid);
    end
    for (int i = 0; i < 4; i++) do_tick(1'($urandom_range(0, 1)), 0);
    n_vec++;
    if (health_fail !== 1'b1 || data_valid !== 1'b0) begin
      n_err++; $display("FAIL hf_sticky: hf=%b valid=%b required 1/0", health_fail, data_valid);
    end
    do_rst();
    n_vec++;
    if (health_fail !== 1'b0) begin n_err++; $display("FAIL hf_clear: hf=%b required 0", health_fail); end
  endtask

  task automatic test_reset_hold();
    do_rst();
    en = 1'b1;
    for (int i = 0; i < 8; i++) feed_acc(1'b1);
    n_vec++;
    if (data_valid !== 1'b1 || data_out !== 8'hFF) begin
      n_err++; $display("FAIL pre_rst: out=%h valid=%b required FF/1", data_out, data_valid);
    end
    rst = 1'b1; data_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; data_ready = 1'b0; en = 1'b0;
    m_reset();
    n_vec++;
    if (data_valid !== 1'b0 || data_out !== 8'h00 || health_fail !== 1'b0) begin
      n_err++; $display("FAIL rst_hold: out=%h valid=%b hf=%b required 00/0/0", data_out, data_valid, health_fail);
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_patterns();
    test_random();
    test_enable_drop();
    test_health();
    test_reset_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
